counter_100: RTL and testbench

COUNTER_100 -- requirements
Module: counter_100

---
 rtl/counter_100_pkg.sv | 17 +
 rtl/counter_100_bcd_digit_add.sv | 26 ++
 rtl/counter_100.sv | 75 +++++++
 tb/tb_counter_100.sv | 139 +++++++++++++
 4 files changed

// File: rtl/counter_100_pkg.sv
// Shared constants for the BCD modulo counter: digit width, digit maximum
// and the step saturation limit, plus the step clamp helper.
package counter_100_pkg;

    localparam int         DIGIT_W    = 4;
    localparam logic [3:0] DIGIT_MAX  = 4'd9;
    localparam logic [3:0] STEP_LIMIT = 4'd9;

    function automatic logic [DIGIT_W-1:0] sat_step(input logic [DIGIT_W-1:0] num);
        if (num > STEP_LIMIT) begin
            return STEP_LIMIT;
        end else begin
            return num;
        end
    endfunction

endpackage

// File: rtl/counter_100_bcd_digit_add.sv
// Single BCD digit adder: digit + addend + carry_in -> BCD digit and decimal carry.
module bcd_digit_add
    import counter_100_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    input  logic [DIGIT_W-1:0] addend,
    input  logic               carry_in,
    output logic [DIGIT_W-1:0] sum,
    output logic               carry_out
);

    logic [DIGIT_W:0] raw_s;

    // Binary sum with decimal adjust; inputs are at most 9, so the raw sum never exceeds 19.
    always_comb begin
        raw_s = {1'b0, digit} + {1'b0, addend} + {{DIGIT_W{1'b0}}, carry_in};
        if (raw_s > {1'b0, DIGIT_MAX}) begin
            sum       = raw_s[DIGIT_W-1:0] - 4'd10;
            carry_out = 1'b1;
        end else begin
            sum       = raw_s[DIGIT_W-1:0];
            carry_out = 1'b0;
        end
    end

endmodule

// File: rtl/counter_100.sv
// Two-digit BCD counter modulo MOD with a saturated step of 0..9 per enabled cycle.
// o_cnt exposes the ones digit straight from its register.
module counter_100
    import counter_100_pkg::*;
#(
    parameter int MOD = 100
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_run,
    input  logic [DIGIT_W-1:0] i_num,
    output logic [DIGIT_W-1:0] o_cnt
);

    localparam logic [DIGIT_W-1:0] TENS_MAX = 4'(MOD / 10 - 1);

    logic [DIGIT_W-1:0] tens_r;
    logic [DIGIT_W-1:0] ones_r;
    logic [DIGIT_W-1:0] step_s;
    logic [DIGIT_W-1:0] ones_sum_s;
    logic [DIGIT_W-1:0] tens_sum_s;
    logic [DIGIT_W-1:0] ones_next_s;
    logic [DIGIT_W-1:0] tens_next_s;
    logic               ones_carry_s;
    logic               tens_carry_s;

    assign step_s = sat_step(i_num);

    bcd_digit_add u_ones (
        .digit     (ones_r),
        .addend    (step_s),
        .carry_in  (1'b0),
        .sum       (ones_sum_s),
        .carry_out (ones_carry_s)
    );

    bcd_digit_add u_tens (
        .digit     (tens_r),
        .addend    (4'd0),
        .carry_in  (ones_carry_s),
        .sum       (tens_sum_s),
        .carry_out (tens_carry_s)
    );

    // Next state: tens rolls to zero past the modulus limit, ones keeps its remainder.
    always_comb begin
        ones_next_s = ones_r;
        tens_next_s = tens_r;
        if (i_run) begin
            ones_next_s = ones_sum_s;
            if (tens_carry_s || (tens_sum_s > TENS_MAX)) begin
                tens_next_s = 4'd0;
            end else begin
                tens_next_s = tens_sum_s;
            end
        end else begin
            ones_next_s = ones_r;
            tens_next_s = tens_r;
        end
    end

    // State registers; reset_n is active-high despite its name.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            tens_r <= 4'd0;
            ones_r <= 4'd0;
        end else begin
            tens_r <= tens_next_s;
            ones_r <= ones_next_s;
        end
    end

    assign o_cnt = ones_r;

endmodule

// File: tb/tb_counter_100.sv
// Self-checking bench for counter_100: directed steps followed by random traffic,
// compared against an integer model of the count.
module tb_counter_100;

    localparam int MOD = 100;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       i_run;
    logic [3:0] i_num;
    logic [3:0] o_cnt;

    int compared   = 0;
    int mismatched = 0;
    int model_c    = 0;

    counter_100 #(.MOD(MOD)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .i_run   (i_run),
        .i_num   (i_num),
        .o_cnt   (o_cnt)
    );

    always #5 clk = ~clk;

    function automatic int eff_step(input int num);
        return (num > 9) ? 9 : num;
    endfunction

    task automatic check(input string tag, input int expected);
        compared++;
        assert (o_cnt === 4'(expected))
        else begin
            mismatched++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, o_cnt, expected);
        end
    endtask

    // Drive inputs, take one rising edge, advance the model, then check.
    task automatic step(input logic run, input int num, input string tag);
        i_run = run;
        i_num = 4'(num);
        @(posedge clk);
        if (run) model_c = (model_c + eff_step(num)) % MOD;
        #1;
        check(tag, model_c % 10);
    endtask

    // Reset pulse between edges, checked while still asserted, released before the next edge.
    task automatic pulse_reset(input string tag);
        reset_n = 1'b1;
        #1;
        model_c = 0;
        check(tag, 0);
        #1;
        reset_n = 1'b0;
    endtask

    initial begin
        int seq[4];
        seq = '{3, 6, 9, 2};

        // Reset held with run active: output stays zero
        reset_n = 1'b1;
        i_run   = 1'b1;
        i_num   = 4'd3;
        @(posedge clk); #1;
        check("reset_edge1", 0);
        @(posedge clk); #1;
        check("reset_edge2", 0);
        reset_n = 1'b0;
        model_c = 0;

        // Basic step sequence 3,6,9,2 then hold
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 3, "basic_step");
            compared++;
            assert (o_cnt === 4'(seq[i]))
            else begin
                mismatched++;
                $error("FAIL basic_seq: observed=%0d expected=%0d", o_cnt, seq[i]);
            end
        end
        for (int i = 0; i < 3; i++) step(1'b0, 3, "basic_hold");

        // Wrap 99 + 3 -> 2
        pulse_reset("wrap_reset");
        for (int i = 0; i < 33; i++) step(1'b1, 3, "wrap_preload");
        check("wrap_at_99", 9);
        step(1'b1, 3, "wrap_99p3");
        check("wrap_result", 2);

        // Wrap 98 + 2 -> 0
        pulse_reset("wrap2_reset");
        for (int i = 0; i < 49; i++) step(1'b1, 2, "wrap2_preload");
        step(1'b1, 2, "wrap2_98p2");
        check("wrap2_result", 0);

        // Step saturation: 12 acts as 9
        pulse_reset("sat_reset");
        step(1'b1, 12, "sat_12");
        check("sat_result", 9);
        step(1'b1, 15, "sat_15");

        // Mid-run reset with step 7
        pulse_reset("mid_reset0");
        step(1'b1, 7, "mid_run1");
        step(1'b1, 7, "mid_run2");
        reset_n = 1'b1;
        #1;
        model_c = 0;
        check("mid_async", 0);
        i_run = 1'b1;
        i_num = 4'd7;
        @(posedge clk); #1;
        check("mid_held", 0);
        reset_n = 1'b0;
        step(1'b1, 7, "mid_resume");
        check("mid_resume_val", 7);

        // Hold while i_num sweeps all values
        step(1'b1, 5, "hold_setup");
        for (int n = 0; n < 16; n++) step(1'b0, n, "hold_sweep");

        // Zero step with run behaves as hold
        step(1'b1, 0, "zero_step");

        // Random traffic with occasional async reset
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) pulse_reset("rand_reset");
            step(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)), "rand_step");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
